// File: rtl/chunked_addsub_unit.sv
// chunked_addsub_unit
//   Multi-cycle two's-complement adder/subtractor. The operation is
//   processed CHUNK bits per clock, LSB chunk first. The carry between
//   chunks is held in a register, so the combinational ripple is only
//   CHUNK bits long regardless of WIDTH.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set present            (input handshake)
//   in_ready   unit can accept an operand set (input handshake)
//   sub        1: a + ~b + c_in, 0: a + b + c_in
//   c_in       carry in (1 together with sub=1 gives a - b)
//   num1       operand a
//   num2       operand b
//   out_valid  result and flags valid         (output handshake)
//   out_ready  consumer takes the result      (output handshake)
//   result     sum / difference, modulo 2^WIDTH
//   c_out      carry out of the MSB (for subtraction 1 = no borrow)
//   overflow   signed overflow
//   zero       result == 0
//   negative   result MSB
//   fsm_state  current FSM state, for observation only
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. Input side: in_ready is 1 only in IDLE. Output side:
// out_valid is 1 only in DONE, where result and flags are stable until
// the edge where out_ready is 1.
module chunked_addsub_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             c_in,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic [1:0]       fsm_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [KW-1:0]    k;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;     // already inverted for subtraction

    logic [CHUNK-1:0] a_sl, b_sl;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] result_nxt;
    logic             last;

    // Select the current chunk with constant part-selects.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (k == i[KW-1:0]) begin
                a_sl = a_q[i*CHUNK +: CHUNK];
                b_sl = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    assign chunk_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
    assign last      = (k == K_LAST);

    // Result with the current chunk merged in; flags on the final chunk
    // are computed from this so they see the complete word.
    always_comb begin
        result_nxt = result;
        for (int i = 0; i < NCHUNK; i++) begin
            if (k == i[KW-1:0]) begin
                result_nxt[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            k        <= '0;
            carry    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result   <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= num1;
                        b_q   <= sub ? ~num2 : num2;
                        carry <= c_in;
                        k     <= '0;
                    end
                end
                BUSY: begin
                    result <= result_nxt;
                    carry  <= chunk_sum[CHUNK];
                    if (last) begin
                        c_out    <= chunk_sum[CHUNK];
                        overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                    (result_nxt[WIDTH-1] != a_q[WIDTH-1]);
                        zero     <= ~|result_nxt;
                        negative <= result_nxt[WIDTH-1];
                        k        <= '0;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_chunked_addsub_unit.sv
module tb_chunked_addsub_unit;

  localparam int W      = 32;
  localparam int CH     = 8;
  localparam int NCHUNK = W / CH;
  localparam int EW     = W + 4;   // {result, c_out, overflow, zero, negative}

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          sub = 1'b0;
  logic          c_in = 1'b0;
  logic [W-1:0]  num1 = '0;
  logic [W-1:0]  num2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic          c_out, overflow, zero, negative;
  logic [1:0]    fsm_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  chunked_addsub_unit #(.WIDTH(W), .CHUNK(CH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sub(sub), .c_in(c_in), .num1(num1), .num2(num2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .c_out(c_out), .overflow(overflow),
    .zero(zero), .negative(negative), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            n_chk  = 0;
  int            n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- monitor ----------------
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !ov_prev) begin
        if (acc_q.size() == 0) check("unexpected_out_valid", 1, 0);
        else check("latency", 64'(cyc - acc_q.pop_front()), 64'(NCHUNK));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else check("result_flags", 64'({result, c_out, overflow, zero, negative}),
                   64'(exp_q.pop_front()));
      end
    end
    ov_prev = rst_n && out_valid;
  end

  // ---------------- driver ----------------
  task automatic wait_in_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
  endtask

  task automatic do_op(input logic s, input logic ci, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] e_res,
                       input logic e_c, input logic e_ovf, input logic e_z,
                       input logic e_n);
    wait_in_ready();
    sub = s; c_in = ci; num1 = a; num2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_q.push_back(cyc);
    exp_q.push_back({e_res, e_c, e_ovf, e_z, e_n});
    // Scramble inputs after accept; the unit must ignore them.
    in_valid = 1'b0;
    sub = ~s; c_in = ~ci; num1 = $urandom; num2 = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 0);
  endtask

  initial begin
    // reset state
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", 64'({result, c_out, overflow, zero, negative}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed vectors: sub, c_in, a, b, result, c_out, ovf, zero, neg
    do_op(1, 1, 32'd10, 32'd3, 32'd7, 1, 0, 0, 0);
    do_op(1, 1, 32'd3, 32'd10, 32'hFFFF_FFF9, 0, 0, 0, 1);
    do_op(0, 0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 1, 0, 1);
    do_op(0, 0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1, 0, 1, 0);
    do_op(1, 1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1, 1, 0, 0);
    do_op(0, 1, 32'h0000_00FF, 32'd1, 32'h0000_0101, 0, 0, 0, 0);
    do_op(1, 0, 32'd10, 32'd3, 32'd6, 1, 0, 0, 0);
    drain();

    // stall in DONE for 5 clocks
    out_ready = 1'b0;
    do_op(0, 0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 0, 0, 0, 0);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    in_valid = 1'b1;   // offered while DONE; must not be accepted
    num1 = 32'hDEAD_BEEF; num2 = 32'h1;
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_result", result, 32'h2345_6789);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    check("after_stall_in_ready", in_ready, 1);

    // reset during BUSY at k=2
    do_op(0, 0, 32'h0F0F_0F0F, 32'h0101_0101, 32'h1010_1010, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_outputs", 64'({result, c_out, overflow, zero, negative}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1, 1, 32'd5, 32'd5, 32'd0, 1, 0, 1, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
